uart_cmd_rx: RTL and testbench

Serial front end for the command path: deserialises 8N1 UART frames from the board's RX pin into a 4-bit instruction nibble and a 4-bit data nibble. Each frame is a byte whose low nibble is `instrucao` and whose high nibble is `dado`. The block drives the parallel `instrucao`/`dado` inputs of the command FSM directly downstream. It also reports frame errors and a one-cycle `valid` strobe per accepted frame.

---
 rtl/uart_cmd_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_cmd_rx.sv | 157 +++++++++++++++
 tb/tb_uart_cmd_rx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command receiver and the downstream command FSM.
// Covers the receiver state encoding, the frame geometry and the instruction codes.
package uart_cmd_pkg;

  localparam int DATA_BITS = 8;
  localparam int NIBBLE_W  = 4;

  localparam logic [NIBBLE_W-1:0] CMD_CLR  = 4'd1;
  localparam logic [NIBBLE_W-1:0] CMD_LOAD = 4'd2;
  localparam logic [NIBBLE_W-1:0] CMD_SHOW = 4'd4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs.
// It resets to all ones so that an idle-high serial line is never mistaken for a start bit.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver that splits each byte into an instruction nibble and a data nibble.
// The instruction is only held for INSTR_HOLD cycles, so downstream logic sees each command once.
module uart_cmd_rx
  import uart_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int INSTR_HOLD   = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rx_in,
  output logic [NIBBLE_W-1:0] instrucao,
  output logic [NIBBLE_W-1:0] dado,
  output logic                valid,
  output logic                frame_err,
  output logic                busy
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int HOLD_W = $clog2(INSTR_HOLD + 1);

  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(INSTR_HOLD);
  localparam logic [2:0]        IDX_LAST  = 3'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 accept_q;
  logic [HOLD_W-1:0]    hold_q;
  logic [NIBBLE_W-1:0]  instr_q;
  logic [NIBBLE_W-1:0]  dado_q;
  logic                 valid_q;
  logic                 err_q;
  logic                 busy_q;

  sync_2ff #(
    .WIDTH(1)
  ) u_rx_sync (
    .clock(clock),
    .reset(reset),
    .d_i  (rx_in),
    .q_o  (rx_s)
  );

  // accept_q delays the nibble update by one cycle after a good stop-bit sample,
  // while the FSM is already back in IDLE and able to catch a back-to-back start bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      accept_q <= 1'b0;
      hold_q   <= '0;
      instr_q  <= '0;
      dado_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      accept_q <= 1'b0;

      if (accept_q) begin
        instr_q <= shift_q[NIBBLE_W-1:0];
        dado_q  <= shift_q[DATA_BITS-1:NIBBLE_W];
        valid_q <= 1'b1;
        hold_q  <= HOLD_LOAD;
      end else if (hold_q != '0) begin
        hold_q <= hold_q - HOLD_W'(1);
        if (hold_q == HOLD_W'(1)) begin
          instr_q <= '0;
        end
      end

      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
              idx_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt_q == FULL_LAST) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s;
            if (idx_q == IDX_LAST) begin
              idx_q   <= '0;
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        STOP: begin
          if (cnt_q == FULL_LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              accept_q <= 1'b1;
              state_q  <= IDLE;
              busy_q   <= 1'b0;
            end else begin
              err_q   <= 1'b1;
              state_q <= WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        WAIT_IDLE: begin
          if (rx_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign instrucao = instr_q;
  assign dado      = dado_q;
  assign valid     = valid_q;
  assign frame_err = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: good frames, back-to-back frames, glitch, framing error,
// mid-frame reset, and a second instance with a one-cycle instruction hold.
module tb_uart_cmd_rx;
  import uart_cmd_pkg::*;

  localparam int CPB = 16;

  logic clock = 1'b0;
  logic reset;
  logic rxA, rxB;
  logic [3:0] instrA, dadoA, instrB, dadoB;
  logic validA, errA, busyA, validB, errB, busyB;

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;
  int startCyc    = 0;

  int vCntA = 0, eCntA = 0, runA = 0, lastRunA = 0;
  int vCntB = 0, eCntB = 0, runB = 0, lastRunB = 0;
  logic sawBusyA = 1'b0;
  logic [3:0] capIA[$], capDA[$], capIB[$], capDB[$];
  int capCycA[$];

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .INSTR_HOLD(2)) dutA (
    .clock    (clock),
    .reset    (reset),
    .rx_in    (rxA),
    .instrucao(instrA),
    .dado     (dadoA),
    .valid    (validA),
    .frame_err(errA),
    .busy     (busyA)
  );

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .INSTR_HOLD(1)) dutB (
    .clock    (clock),
    .reset    (reset),
    .rx_in    (rxB),
    .instrucao(instrB),
    .dado     (dadoB),
    .valid    (validB),
    .frame_err(errB),
    .busy     (busyB)
  );

  // Monitors sample on the falling edge, away from the edge that updates the DUT.
  always @(negedge clock) begin
    if (validA) begin
      vCntA++;
      capIA.push_back(instrA);
      capDA.push_back(dadoA);
      capCycA.push_back(cyc);
    end
    if (errA) eCntA++;
    if (busyA) sawBusyA = 1'b1;
    if (instrA != 4'd0) runA++;
    else if (runA != 0) begin
      lastRunA = runA;
      runA = 0;
    end
  end

  always @(negedge clock) begin
    if (validB) begin
      vCntB++;
      capIB.push_back(instrB);
      capDB.push_back(dadoB);
    end
    if (errB) eCntB++;
    if (instrB != 4'd0) runB++;
    else if (runB != 0) begin
      lastRunB = runB;
      runB = 0;
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic driveRx(input bit toB, input logic v);
    if (toB) rxB = v;
    else     rxA = v;
  endtask

  // Sends start bit, the first nBits data bits LSB first, and (only for a full byte) the
  // stop level for stopCycles; must be called right after a falling clock edge.
  task automatic applyStimulus(input bit toB, input logic [7:0] frame, input logic stopBit,
                               input int stopCycles, input int nBits);
    startCyc = cyc;
    driveRx(toB, 1'b0);
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < nBits; i++) begin
      driveRx(toB, frame[i]);
      repeat (CPB) @(negedge clock);
    end
    if (nBits == DATA_BITS) begin
      driveRx(toB, stopBit);
      repeat (stopCycles) @(negedge clock);
    end
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    rxA   = 1'b1;
    rxB   = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    checkOutput("reset_instr", instrA, 0);
    checkOutput("reset_dado", dadoA, 0);
    checkOutput("reset_valid", validA, 0);
    checkOutput("reset_frame_err", errA, 0);
    checkOutput("reset_busy", busyA, 0);

    applyStimulus(1'b0, 8'h52, 1'b1, CPB, 8);
    repeat (10) @(negedge clock);
    lat = (capCycA.size() > 0) ? capCycA[0] - startCyc : -1;
    checkOutput("f52_valid_count", vCntA, 1);
    checkOutput("f52_instr", (capIA.size() > 0) ? int'(capIA[0]) : 32'hDEAD, int'(CMD_LOAD));
    checkOutput("f52_dado", (capDA.size() > 0) ? int'(capDA[0]) : 32'hDEAD, 5);
    checkOutput("f52_latency_window", int'(lat >= 150 && lat <= 160), 1);
    checkOutput("f52_instr_hold_len", lastRunA, 2);
    checkOutput("f52_instr_cleared", instrA, 0);
    checkOutput("f52_dado_held", dadoA, 5);
    checkOutput("f52_no_frame_err", eCntA, 0);
    checkOutput("f52_busy_idle", busyA, 0);

    applyStimulus(1'b0, 8'h31, 1'b1, CPB, 8);
    applyStimulus(1'b0, 8'hA4, 1'b1, CPB, 8);
    repeat (10) @(negedge clock);
    checkOutput("b2b_valid_count", vCntA, 3);
    checkOutput("b2b_first_instr", (capIA.size() > 1) ? int'(capIA[1]) : 32'hDEAD, int'(CMD_CLR));
    checkOutput("b2b_first_dado", (capDA.size() > 1) ? int'(capDA[1]) : 32'hDEAD, 3);
    checkOutput("b2b_second_instr", (capIA.size() > 2) ? int'(capIA[2]) : 32'hDEAD, int'(CMD_SHOW));
    checkOutput("b2b_second_dado", (capDA.size() > 2) ? int'(capDA[2]) : 32'hDEAD, 10);
    checkOutput("b2b_instr_hold_len", lastRunA, 2);

    sawBusyA = 1'b0;
    rxA = 1'b0;
    repeat (5) @(negedge clock);
    rxA = 1'b1;
    repeat (30) @(negedge clock);
    checkOutput("glitch_busy_seen", sawBusyA, 1);
    checkOutput("glitch_busy_idle", busyA, 0);
    checkOutput("glitch_no_valid", vCntA, 3);
    checkOutput("glitch_dado_kept", dadoA, 10);
    checkOutput("glitch_instr_zero", instrA, 0);

    applyStimulus(1'b0, 8'h52, 1'b0, 40, 8);
    checkOutput("ferr_pulse_count", eCntA, 1);
    checkOutput("ferr_no_valid", vCntA, 3);
    checkOutput("ferr_dado_kept", dadoA, 10);
    checkOutput("ferr_busy_while_low", busyA, 1);
    rxA = 1'b1;
    repeat (200) @(negedge clock);
    checkOutput("ferr_busy_after_high", busyA, 0);
    checkOutput("ferr_no_phantom_frame", vCntA, 3);
    checkOutput("ferr_single_pulse", eCntA, 1);

    applyStimulus(1'b0, 8'h52, 1'b1, CPB, 4);
    rxA = 1'b1;
    repeat (8) @(negedge clock);
    checkOutput("rst_busy_mid_frame", busyA, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_async_instr", instrA, 0);
    checkOutput("rst_async_dado", dadoA, 0);
    checkOutput("rst_async_valid", validA, 0);
    checkOutput("rst_async_frame_err", errA, 0);
    checkOutput("rst_async_busy", busyA, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    applyStimulus(1'b0, 8'h72, 1'b1, CPB, 8);
    repeat (10) @(negedge clock);
    checkOutput("rst_next_valid_count", vCntA, 4);
    checkOutput("rst_next_instr", (capIA.size() > 3) ? int'(capIA[3]) : 32'hDEAD, int'(CMD_LOAD));
    checkOutput("rst_next_dado", (capDA.size() > 3) ? int'(capDA[3]) : 32'hDEAD, 7);

    applyStimulus(1'b1, 8'h14, 1'b1, CPB, 8);
    repeat (10) @(negedge clock);
    checkOutput("hold1_valid_count", vCntB, 1);
    checkOutput("hold1_instr", (capIB.size() > 0) ? int'(capIB[0]) : 32'hDEAD, int'(CMD_SHOW));
    checkOutput("hold1_dado", (capDB.size() > 0) ? int'(capDB[0]) : 32'hDEAD, 1);
    checkOutput("hold1_instr_len", lastRunB, 1);
    checkOutput("hold1_instr_cleared", instrB, 0);
    checkOutput("hold1_no_frame_err", eCntB, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
